// File: rtl/reg_desplazamiento_universal.sv
// Universal shift register: shift left/right, rotate left, parallel load,
// with a saturating step counter and a one-cycle DONE pulse on reaching WIDTH.
// Ports: CLK, RESET_L (async active-low), ENB (hold when 0), MODO (op select),
//        D (load data), S_IN (serial in) -> Q, S_OUT, CNT, DONE.
// Latency: one cycle, all outputs registered. No backpressure: ENB=0 freezes state.
module reg_desplazamiento_universal #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic             S_IN,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic [CW-1:0]    CNT,
  output logic             DONE
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    MODE_SHL  = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_ROL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  logic [WIDTH-1:0] q_nxt;
  logic             s_out_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             done_nxt;
  logic             step;

  always_comb begin
    q_nxt     = Q;
    s_out_nxt = S_OUT;
    cnt_nxt   = CNT;
    done_nxt  = 1'b0;
    step      = 1'b0;
    if (ENB) begin
      case (mode_t'(MODO))
        MODE_SHL: begin
          q_nxt     = {Q[WIDTH-2:0], S_IN};
          s_out_nxt = Q[WIDTH-1];
          step      = 1'b1;
        end
        MODE_SHR: begin
          q_nxt     = {S_IN, Q[WIDTH-1:1]};
          s_out_nxt = Q[0];
          step      = 1'b1;
        end
        MODE_ROL: begin
          q_nxt     = {Q[WIDTH-2:0], Q[WIDTH-1]};
          s_out_nxt = Q[WIDTH-1];
          step      = 1'b1;
        end
        default: begin
          q_nxt     = D;
          s_out_nxt = 1'b0;
          cnt_nxt   = '0;
        end
      endcase
      // Counter saturates at WIDTH; DONE fires only on the WIDTH-1 -> WIDTH
      // transition, so a saturated counter never re-pulses until a load.
      if (step && (CNT < CNT_MAX)) begin
        cnt_nxt  = CNT + CNT_ONE;
        done_nxt = (CNT == CNT_MAX - CNT_ONE);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      Q     <= '0;
      S_OUT <= 1'b0;
      CNT   <= '0;
      DONE  <= 1'b0;
    end else begin
      Q     <= q_nxt;
      S_OUT <= s_out_nxt;
      CNT   <= cnt_nxt;
      DONE  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_reg_desplazamiento_universal.sv
// Self-checking bench for reg_desplazamiento_universal (WIDTH=4): an
// arithmetic reference model checked every negedge, plus directed literal checks.
module tb_reg_desplazamiento_universal;
  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          CLK = 1'b0;
  logic          RESET_L;
  logic          ENB;
  logic [1:0]    MODO;
  logic [W-1:0]  D;
  logic          S_IN;
  logic [W-1:0]  Q;
  logic          S_OUT;
  logic [CW-1:0] CNT;
  logic          DONE;

  int tests = 0;
  int fails = 0;

  // reference model state (plain integers)
  int m_q, m_s, m_cnt, m_done;

  reg_desplazamiento_universal #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .MODO(MODO), .D(D),
    .S_IN(S_IN), .Q(Q), .S_OUT(S_OUT), .CNT(CNT), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: arithmetic view of shift/rotate on a W-bit number.
  always @(posedge CLK or negedge RESET_L) begin
    int full, top, bot;
    full = 1 << W;
    if (!RESET_L) begin
      m_q = 0; m_s = 0; m_cnt = 0; m_done = 0;
    end else if (!ENB) begin
      m_done = 0;
    end else if (MODO == 2'b11) begin
      m_q = int'(D); m_s = 0; m_cnt = 0; m_done = 0;
    end else begin
      top = m_q / (full / 2);
      bot = m_q % 2;
      case (MODO)
        2'b00: begin m_s = top; m_q = (m_q * 2 + int'(S_IN)) % full; end
        2'b01: begin m_s = bot; m_q = m_q / 2 + int'(S_IN) * (full / 2); end
        default: begin m_s = top; m_q = (m_q * 2) % full + top; end
      endcase
      if (m_cnt < W) begin
        m_cnt = m_cnt + 1;
        m_done = (m_cnt == W) ? 1 : 0;
      end else begin
        m_done = 0;
      end
    end
  end

  // Continuous comparison against the model.
  always @(negedge CLK) begin
    check("model_q", int'(Q), m_q);
    check("model_s_out", int'(S_OUT), m_s);
    check("model_cnt", int'(CNT), m_cnt);
    check("model_done", int'(DONE), m_done);
  end

  // Apply inputs, then let one rising edge pass; returns 2 time units after it.
  task automatic cyc(input logic e, input logic [1:0] m, input logic [W-1:0] d, input logic s);
    ENB = e; MODO = m; D = d; S_IN = s;
    @(posedge CLK); #2;
  endtask

  task automatic lit(input string name, input int q, input int s, input int c, input int dn);
    check({name, "_q"}, int'(Q), q);
    check({name, "_s_out"}, int'(S_OUT), s);
    check({name, "_cnt"}, int'(CNT), c);
    check({name, "_done"}, int'(DONE), dn);
  endtask

  initial begin
    int exp_q[4], exp_s[4];
    RESET_L = 1'b0; ENB = 1'b0; MODO = 2'b00; D = '0; S_IN = 1'b0;
    cyc(0, 2'b00, 4'h0, 0);
    cyc(0, 2'b00, 4'h0, 0);
    lit("reset", 0, 0, 0, 0);
    RESET_L = 1'b1;

    // Asynchronous reset mid-operation
    cyc(1, 2'b11, 4'b1011, 0);
    lit("load1011", 11, 0, 0, 0);
    ENB = 1'b1; MODO = 2'b00;
    #1 RESET_L = 1'b0;
    #1 lit("async_rst", 0, 0, 0, 0);
    cyc(0, 2'b00, 4'h0, 0);
    RESET_L = 1'b1;
    cyc(1, 2'b11, 4'b0110, 0);
    lit("post_rst_load", 6, 0, 0, 0);

    // Load then shift left
    cyc(1, 2'b11, 4'b1001, 0);
    exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0000};
    exp_s = '{1, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      cyc(1, 2'b00, 4'h0, 0);
      lit($sformatf("shl%0d", i), exp_q[i], exp_s[i], i + 1, (i == 3) ? 1 : 0);
    end
    cyc(0, 2'b00, 4'h0, 0);
    lit("shl_idle", 0, 1, 4, 0);

    // Shift right with S_IN=1 from 0000
    cyc(1, 2'b11, 4'b0000, 0);
    exp_q = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      cyc(1, 2'b01, 4'h0, 1);
      lit($sformatf("shr%0d", i), exp_q[i], 0, i + 1, (i == 3) ? 1 : 0);
    end

    // Rotate left; S_IN toggled to show it is ignored
    cyc(1, 2'b11, 4'b1010, 0);
    exp_q = '{4'b0101, 4'b1010, 4'b0101, 4'b1010};
    exp_s = '{1, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      cyc(1, 2'b10, 4'h0, i[0]);
      lit($sformatf("rol%0d", i), exp_q[i], exp_s[i], i + 1, (i == 3) ? 1 : 0);
    end

    // Enable hold mid-shift, then saturation
    cyc(1, 2'b11, 4'b0110, 0);
    cyc(1, 2'b00, 4'h0, 1);
    lit("hold_pre0", 4'b1101, 0, 1, 0);
    cyc(1, 2'b00, 4'h0, 1);
    lit("hold_pre1", 4'b1011, 1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 2'b11, 4'hF, 0);  // MODO/D noise must not matter while ENB=0
      lit($sformatf("hold%0d", i), 4'b1011, 1, 2, 0);
    end
    cyc(1, 2'b00, 4'h0, 1);
    lit("sat0", 4'b0111, 1, 3, 0);
    cyc(1, 2'b00, 4'h0, 1);
    lit("sat1", 4'b1111, 0, 4, 1);
    cyc(1, 2'b00, 4'h0, 0);
    lit("sat2", 4'b1110, 1, 4, 0);
    cyc(1, 2'b00, 4'h0, 0);
    lit("sat3", 4'b1100, 1, 4, 0);
    cyc(1, 2'b11, 4'b0011, 0);
    lit("reload", 4'b0011, 0, 0, 0);

    // MODO glitch between edges has no effect: only the sampled value counts
    ENB = 1'b1; MODO = 2'b11; D = 4'hF;
    #1 MODO = 2'b01; S_IN = 1'b0;
    @(posedge CLK); #2;
    lit("glitch", 4'b0001, 1, 1, 0);

    // Boundary: reset coincident with the edge that would saturate CNT
    cyc(1, 2'b01, 4'h0, 0);
    cyc(1, 2'b01, 4'h0, 0);
    lit("bnd_pre", 0, 0, 3, 0);
    ENB = 1'b1; MODO = 2'b00;
    @(negedge CLK); #5;
    RESET_L = 1'b0;
    #2 lit("bnd_rst", 0, 0, 0, 0);
    cyc(1, 2'b00, 4'h0, 0);
    lit("bnd_hold", 0, 0, 0, 0);
    RESET_L = 1'b1;
    cyc(1, 2'b11, 4'b0101, 0);
    lit("bnd_load", 4'b0101, 0, 0, 0);
    cyc(0, 2'b00, 4'h0, 0);

    @(negedge CLK); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    fails++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
